// File: rtl/ram16k_pkg.sv
// Shared widths and types for the 16K-word data memory and its 4K banks.
package ram16k_pkg;

    localparam int unsigned DATA_W      = 16;
    localparam int unsigned ADDR_W      = 14;
    localparam int unsigned BANK_SEL_W  = 2;
    localparam int unsigned BANK_ADDR_W = 12;
    localparam int unsigned NUM_BANKS   = 1 << BANK_SEL_W;
    localparam int unsigned BANK_DEPTH  = 1 << BANK_ADDR_W;

    typedef logic [DATA_W-1:0] word_t;

endpackage : ram16k_pkg

// File: rtl/ram16k_ram4k.sv
// ram4k: 4096 x DATA_W register bank.
//   clk     - write clock (rising edge)
//   reset   - asynchronous active-high clear of every word
//   load    - write enable sampled at the rising edge
//   address - word address within the bank
//   in      - write data
//   out     - combinational read of the addressed word
module ram4k
    import ram16k_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [BANK_ADDR_W-1:0] address,
    input  logic [DATA_W-1:0]      in,
    output logic [DATA_W-1:0]      out
);

    word_t mem_q [BANK_DEPTH];
    word_t mem_d [BANK_DEPTH];

    // Next-state of the array: only the addressed word can change.
    always_comb begin
        mem_d = mem_q;
        if (load) begin
            mem_d[address] = in;
        end
    end

    // Reset clears the whole bank regardless of load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    // Zero-latency read; no bypass of in, so a same-address write shows after the edge.
    assign out = mem_q[address];

endmodule : ram4k

// File: rtl/ram16k.sv
// ram16k: 16384 x DATA_W data memory built from four ram4k banks.
//   clk     - write clock (rising edge)
//   reset   - asynchronous active-high clear of every word
//   load    - write enable sampled at the rising edge
//   address - word address; [13:12] picks the bank, [11:0] the word
//   in      - write data
//   out     - combinational read of the addressed word
module ram16k
    import ram16k_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] in,
    output logic [DATA_W-1:0] out
);

    logic [BANK_SEL_W-1:0]  bank_sel;
    logic [BANK_ADDR_W-1:0] bank_addr;
    logic [NUM_BANKS-1:0]   load_bank;
    word_t                  bank_out [NUM_BANKS];

    assign bank_sel  = address[ADDR_W-1:BANK_ADDR_W];
    assign bank_addr = address[BANK_ADDR_W-1:0];

    // Route load only to the selected bank.
    always_comb begin
        load_bank = '0;
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            load_bank[b] = load && (bank_sel == BANK_SEL_W'(b));
        end
    end

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        ram4k u_bank (
            .clk     (clk),
            .reset   (reset),
            .load    (load_bank[g]),
            .address (bank_addr),
            .in      (in),
            .out     (bank_out[g])
        );
    end

    // Output mux driven by the bank-select bits.
    assign out = bank_out[bank_sel];

endmodule : ram16k

// File: tb/tb_ram16k.sv
// Self-checking bench for ram16k against a flat-array reference memory.
module tb_ram16k;

    logic        clk;
    logic        reset;
    logic        load;
    logic [13:0] address;
    logic [15:0] din;
    logic [15:0] dout;

    int tests;
    int fails;

    logic [15:0] model [16384];
    logic [13:0] hot_addr [10];

    ram16k dut (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .address (address),
        .in      (din),
        .out     (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] exp);
        tests++;
        assert (dout === exp)
        else begin
            fails++;
            $error("FAIL %s: addr=%0d out=%h expected=%h", tag, address, dout, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16384; i++) model[i] = 16'h0000;
    endtask

    // Write one word on the next rising edge, then drop load.
    task automatic write_word(input logic [13:0] a, input logic [15:0] d);
        @(negedge clk);
        address = a;
        din     = d;
        load    = 1'b1;
        @(posedge clk);
        model[a] = d;
        #1;
        load = 1'b0;
    endtask

    // Apply an address mid-cycle with load low and check the same-cycle read.
    task automatic read_check(input string tag, input logic [13:0] a);
        @(negedge clk);
        load    = 1'b0;
        address = a;
        #1;
        check(tag, model[a]);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset   = 1'b1;
        load    = 1'b0;
        address = '0;
        din     = '0;
        model_clear();

        hot_addr[0] = 14'd0;     hot_addr[1] = 14'd4095;
        hot_addr[2] = 14'd4096;  hot_addr[3] = 14'd8191;
        hot_addr[4] = 14'd8192;  hot_addr[5] = 14'd12287;
        hot_addr[6] = 14'd12288; hot_addr[7] = 14'd16383;
        hot_addr[8] = 14'd4000;  hot_addr[9] = 14'd8000;

        // Reset then read
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        read_check("rst_0", 14'd0);
        read_check("rst_4000", 14'd4000);
        read_check("rst_8000", 14'd8000);
        read_check("rst_16383", 14'd16383);

        // Writes across banks then readback
        write_word(14'd0,     16'hA000);
        write_word(14'd4000,  16'hB111);
        write_word(14'd8000,  16'hC222);
        write_word(14'd16383, 16'hDFFF);
        read_check("rb_0", 14'd0);
        read_check("rb_4000", 14'd4000);
        read_check("rb_8000", 14'd8000);
        read_check("rb_16383", 14'd16383);
        tests++;
        assert (model[0] == 16'hA000 && model[16383] == 16'hDFFF && dout === 16'hDFFF)
        else begin
            fails++;
            $error("FAIL rb_const: out=%h expected=%h", dout, 16'hDFFF);
        end

        // Overwrite
        write_word(14'd8000, 16'hEEEE);
        read_check("ow_8000", 14'd8000);
        read_check("ow_0", 14'd0);
        read_check("ow_4000", 14'd4000);
        read_check("ow_16383", 14'd16383);

        // load=0 hold
        @(negedge clk);
        address = 14'd4000;
        din     = 16'h1234;
        load    = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("hold_4000", 16'hB111);

        // Read-during-write on the same address
        @(negedge clk);
        address = 14'd0;
        din     = 16'h5555;
        load    = 1'b1;
        #1;
        check("rdw_before", 16'hA000);
        @(posedge clk);
        model[0] = 16'h5555;
        #1;
        load = 1'b0;
        check("rdw_after", 16'h5555);

        // Randomized traffic biased toward bank edges
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 2) == 0) address = 14'($urandom_range(0, 16383));
            else address = hot_addr[$urandom_range(0, 9)];
            din  = 16'($urandom);
            load = 1'($urandom_range(0, 1));
            #1;
            check("rnd_pre", model[address]);
            @(posedge clk);
            if (load) model[address] = din;
            #1;
            check("rnd_post", model[address]);
        end
        for (int i = 0; i < 10; i++) read_check("rnd_sweep", hot_addr[i]);

        // Asynchronous reset between edges
        write_word(14'd16383, 16'h7E57);
        @(negedge clk);
        load    = 1'b0;
        address = 14'd16383;
        #2;
        reset = 1'b1;
        model_clear();
        #1;
        check("async_rst_now", 16'h0000);
        address = 14'd0;     #1; check("arst_0", model[0]);
        address = 14'd4000;  #1; check("arst_4000", model[4000]);
        address = 14'd8000;  #1; check("arst_8000", model[8000]);
        address = 14'd16383; #1; check("arst_16383", model[16383]);

        // Edge with reset and load both high writes nothing
        @(negedge clk);
        address = 14'd8000;
        din     = 16'hBEEF;
        load    = 1'b1;
        @(posedge clk);
        #1;
        check("rst_ld_during", 16'h0000);
        @(negedge clk);
        load  = 1'b0;
        reset = 1'b0;
        #1;
        check("rst_ld_after", 16'h0000);
        read_check("post_rst_0", 14'd0);
        read_check("post_rst_16383", 14'd16383);

        // Normal writes resume after reset
        write_word(14'd12288, 16'h0F0F);
        read_check("resume_12288", 14'd12288);
        read_check("resume_12287", 14'd12287);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_ram16k

// File: doc/ram16k.md
Name: ram16k

Overview:
- 16384-word × 16-bit random-access register memory (Hack-style RAM16K).
- Synchronous write on the clock's rising edge; combinational (zero-latency) read of the addressed word.
- Sits in the data-memory path of the CPU/computer level.
- Built as four 4K banks selected by the top two address bits.

Parameters:
- DATA_W, 16, word width in bits
- ADDR_W, 14, address width; depth = 2**ADDR_W words (16384)

Ports:
- clk  input  1  system clock; all writes occur on its rising edge
- reset  input  1  asynchronous, active-high reset; clears every word to 0
- load  input  1  write enable, sampled at the rising edge of clk
- address  input  ADDR_W  word address, 0..16383
- in  input  DATA_W  write data
- out  output  DATA_W  contents of the word at address

Behaviour:
- Storage is an array of 2**ADDR_W registers of DATA_W bits.
- Reset:
  - reset=1 asynchronously forces every word to 16'h0000, independent of clk.
  - out reads 0 at any address while reset is high and after it is released, until the word is written.
  - Reset has priority over load. A rising edge with reset=1 and load=1 writes nothing.
- Write:
  - At a rising clk edge with reset=0 and load=1, mem[address] <= in.
  - Exactly one word changes. All others hold.
  - With load=0, no word changes.
- Read:
  - out = mem[address] combinationally, with no clock latency.
  - A change of address updates out within the same cycle.
- Read-during-write, same address:
  - Before the edge, out shows the old contents.
  - After the edge, out shows the newly written value. No write-through bypass of in to out.
- Address decode:
  - address[13:12] selects bank 0..3.
  - address[11:0] selects the word within the bank.
  - load is routed only to the selected bank.
  - out is a 4:1 mux of the bank outputs driven by address[13:12].
- Boundaries:
  - address 0 and 16383 are valid and independent.
  - No wrap-around or aliasing: each of the 16384 addresses maps to a unique word.
- X/undriven address or load inputs are not guarded. The bench must keep them driven.

Decomposition:
- Shared package holds:
  - DATA_W=16 and ADDR_W=14
  - BANK_SEL_W=2
  - BANK_ADDR_W=12
  - a word typedef logic [DATA_W-1:0]
- One natural sub-module, ram4k:
  - 4096 × DATA_W registers with the same clk, reset, load, address[11:0], in and out contract.
  - Instantiated four times by ram16k.
- ram16k itself contains only the load demux and the output mux.

Test Plan:
- Reset then read:
  - Assert reset, release it, then read addresses 0, 4000, 8000 and 16383 with load=0.
  - out = 16'h0000 at each.
- Writes across banks then readback:
  - Write 16'hA000 @0, 16'hB111 @4000, 16'hC222 @8000, 16'hDFFF @16383 on successive edges.
  - Then set load=0 and step the address through the same four locations.
  - out = A000, B111, C222, DFFF respectively, each visible in the same cycle the address is applied.
- Overwrite:
  - Write 16'hEEEE @8000, then read @8000 → EEEE.
  - Reads @0, @4000 and @16383 remain A000, B111, DFFF.
- load=0 hold:
  - Present in=16'h1234 @4000 with load=0 for several edges.
  - out stays B111.
- Read-during-write timing:
  - With address=0 holding A000, set in=16'h5555 and load=1 mid-cycle.
  - out = A000 until the rising edge, then 5555.
- Asynchronous reset mid-operation:
  - After the writes above, pulse reset between clock edges.
  - out becomes 0000 immediately, without waiting for an edge.
  - All four test addresses read 0000 afterwards.
  - An edge with reset=1 and load=1 does not write.
